// File: rtl/eccop_opram_rmw.sv
// rtl/eccop_opram_rmw.sv - ECC coprocessor operand RAM with ALU port, byte-enabled bus RMW and zeroize sweep
//
// Purpose: N_REG x OP_W operand store. One RAM read port (ALU first, then bus)
// and one RAM write port (zeroize sweep, then ALU, then bus RMW). All RAM
// reads are write-first: a same-cycle write to the row being read is
// forwarded into the read result.
//
// Ports:
//   clk, arstn          clock, asynchronous active-low reset
//   bus_*               32-bit Avalon-MM slave, word address = {row, word}
//   op_read/op_raddr    ALU read strobe/row, op_rdata valid next cycle and held
//   op_write/op_waddr   ALU write strobe/row with op_wdata, never stalls
//   zeroize             pulse starting an all-rows clear
//   zeroize_busy        high for the N_REG cycles of the sweep
module eccop_opram_rmw #(
  parameter int OP_W  = 260,
  parameter int N_REG = 64,
  parameter int WPO   = 16,
  parameter int RA_W  = 6,
  parameter int WA_W  = 4
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [RA_W+WA_W-1:0] bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_be,
  input  logic                 bus_write,
  input  logic                 bus_read,
  output logic                 bus_waitrequest,
  output logic [31:0]          bus_rdata,
  input  logic                 op_read,
  input  logic [RA_W-1:0]      op_raddr,
  output logic [OP_W-1:0]      op_rdata,
  input  logic                 op_write,
  input  logic [RA_W-1:0]      op_waddr,
  input  logic [OP_W-1:0]      op_wdata,
  input  logic                 zeroize,
  output logic                 zeroize_busy
);

  localparam int EXT_W = WPO * 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRD,
    S_RMW_RD,
    S_RMW_WR,
    S_ZERO
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [OP_W-1:0]   r_mem [N_REG];
  logic [OP_W-1:0]   r_row;
  logic [OP_W-1:0]   r_merged;
  logic [OP_W-1:0]   r_op_rdata;
  logic [31:0]       r_bus_rdata;
  logic [RA_W-1:0]   r_zcnt;
  logic              r_zpend;
  logic              r_stale;

  logic [RA_W-1:0]   w_bus_row;
  logic [WA_W-1:0]   w_bus_word;
  logic              w_op_rd;
  logic [RA_W-1:0]   w_raddr;
  logic [OP_W-1:0]   w_rd_data;
  logic              w_we;
  logic [RA_W-1:0]   w_waddr;
  logic [OP_W-1:0]   w_wdata;
  logic              w_same_row;
  logic              w_bus_rd_iss;
  logic              w_rmw_rd_iss;
  logic              w_merge;
  logic              w_bus_wr;
  logic              w_stale_set;
  logic              w_stale_clr;
  logic              w_wait;

  // Word k of a row, zero-extended past OP_W so unmapped bits/words read 0.
  function automatic logic [31:0] f_word(input logic [OP_W-1:0] row,
                                         input logic [WA_W-1:0] k);
    logic [EXT_W-1:0] ext;
    ext = '0;
    ext[OP_W-1:0] = row;
    return ext[k*32 +: 32];
  endfunction

  // Byte-enabled merge; bytes landing beyond OP_W fall off on truncation.
  function automatic logic [OP_W-1:0] f_merge(input logic [OP_W-1:0] row,
                                              input logic [WA_W-1:0] k,
                                              input logic [31:0]     wd,
                                              input logic [3:0]      be);
    logic [EXT_W-1:0] ext;
    ext = '0;
    ext[OP_W-1:0] = row;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ext[k*32 + b*8 +: 8] = wd[b*8 +: 8];
    end
    return ext[OP_W-1:0];
  endfunction

  assign w_bus_row  = bus_addr[RA_W+WA_W-1:WA_W];
  assign w_bus_word = bus_addr[WA_W-1:0];
  assign w_same_row = (op_waddr == w_bus_row);

  // ALU reads are not served while the sweep runs; op_rdata is forced to 0.
  assign w_op_rd = op_read && (r_state != S_ZERO);
  assign w_raddr = w_op_rd ? op_raddr : w_bus_row;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_zcnt;
    w_wdata = '0;
    if (r_state == S_ZERO) begin
      w_we = 1'b1;
    end else if (op_write) begin
      w_we    = 1'b1;
      w_waddr = op_waddr;
      w_wdata = op_wdata;
    end else if (w_bus_wr) begin
      w_we    = 1'b1;
      w_waddr = w_bus_row;
      w_wdata = r_merged;
    end
  end

  assign w_rd_data = (w_we && (w_waddr == w_raddr)) ? w_wdata : r_mem[w_raddr];

  always_comb begin
    w_nxt        = r_state;
    w_bus_rd_iss = 1'b0;
    w_rmw_rd_iss = 1'b0;
    w_merge      = 1'b0;
    w_bus_wr     = 1'b0;
    w_stale_set  = 1'b0;
    w_stale_clr  = 1'b0;
    w_wait       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (zeroize || r_zpend) begin
          w_nxt = S_ZERO;
        end else if (bus_write) begin
          if (!op_read) begin
            w_rmw_rd_iss = 1'b1;
            w_nxt        = S_RMW_RD;
          end
        end else if (bus_read) begin
          if (!op_read) begin
            w_bus_rd_iss = 1'b1;
            w_nxt        = S_BRD;
          end
        end
      end
      S_BRD: begin
        w_wait = 1'b0;
        w_nxt  = S_IDLE;
      end
      S_RMW_RD: begin
        w_merge = 1'b1;
        // An ALU write landing now is newer than r_row: merge must be redone.
        if (op_write && w_same_row) w_stale_set = 1'b1;
        w_nxt = S_RMW_WR;
      end
      S_RMW_WR: begin
        if (op_write) begin
          if (w_same_row) w_stale_set = 1'b1;
        end else if (r_stale) begin
          if (!op_read) begin
            w_rmw_rd_iss = 1'b1;
            w_stale_clr  = 1'b1;
            w_nxt        = S_RMW_RD;
          end
        end else begin
          w_bus_wr = 1'b1;
          w_wait   = 1'b0;
          w_nxt    = S_IDLE;
        end
      end
      S_ZERO: begin
        if (r_zcnt == RA_W'(N_REG - 1)) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= S_IDLE;
      r_zcnt      <= '0;
      r_zpend     <= 1'b0;
      r_stale     <= 1'b0;
      r_row       <= '0;
      r_merged    <= '0;
      r_op_rdata  <= '0;
      r_bus_rdata <= '0;
    end else begin
      r_state <= w_nxt;

      if (r_state == S_ZERO) r_zcnt <= r_zcnt + 1'b1;
      else                   r_zcnt <= '0;

      // A pulse outside IDLE waits for IDLE; one during the sweep is dropped.
      if (r_state == S_IDLE)                         r_zpend <= 1'b0;
      else if (zeroize && (r_state != S_ZERO))       r_zpend <= 1'b1;

      if (r_state == S_IDLE)   r_stale <= 1'b0;
      else if (w_stale_set)    r_stale <= 1'b1;
      else if (w_stale_clr)    r_stale <= 1'b0;

      if (w_rmw_rd_iss) r_row <= w_rd_data;
      if (w_merge)      r_merged <= f_merge(r_row, w_bus_word, bus_wdata, bus_be);
      if (w_bus_rd_iss) r_bus_rdata <= f_word(w_rd_data, w_bus_word);

      if (r_state == S_ZERO) r_op_rdata <= '0;
      else if (op_read)      r_op_rdata <= w_rd_data;
    end
  end

  // Row contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign bus_waitrequest = w_wait;
  assign bus_rdata       = r_bus_rdata;
  assign op_rdata        = r_op_rdata;
  assign zeroize_busy    = (r_state == S_ZERO);

endmodule

// File: tb/tb_eccop_opram_rmw.sv
// tb/tb_eccop_opram_rmw.sv - directed self-checking bench for eccop_opram_rmw
module tb_eccop_opram_rmw;

  localparam int OP_W  = 260;
  localparam int N_REG = 64;
  localparam int WPO   = 16;
  localparam int RA_W  = 6;
  localparam int WA_W  = 4;

  logic                 clk;
  logic                 arstn;
  logic [RA_W+WA_W-1:0] bus_addr;
  logic [31:0]          bus_wdata;
  logic [3:0]           bus_be;
  logic                 bus_write;
  logic                 bus_read;
  logic                 bus_waitrequest;
  logic [31:0]          bus_rdata;
  logic                 op_read;
  logic [RA_W-1:0]      op_raddr;
  logic [OP_W-1:0]      op_rdata;
  logic                 op_write;
  logic [RA_W-1:0]      op_waddr;
  logic [OP_W-1:0]      op_wdata;
  logic                 zeroize;
  logic                 zeroize_busy;

  int n_chk  = 0;
  int n_pass = 0;

  eccop_opram_rmw #(
    .OP_W(OP_W), .N_REG(N_REG), .WPO(WPO), .RA_W(RA_W), .WA_W(WA_W)
  ) dut (
    .clk(clk), .arstn(arstn),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_write(bus_write), .bus_read(bus_read),
    .bus_waitrequest(bus_waitrequest), .bus_rdata(bus_rdata),
    .op_read(op_read), .op_raddr(op_raddr), .op_rdata(op_rdata),
    .op_write(op_write), .op_waddr(op_waddr), .op_wdata(op_wdata),
    .zeroize(zeroize), .zeroize_busy(zeroize_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OP_W-1:0] fill(input logic [7:0] b);
    logic [OP_W-1:0] r;
    for (int i = 0; i < OP_W; i++) r[i] = b[3'(i % 8)];
    return r;
  endfunction

  task automatic op_wr(input logic [RA_W-1:0] row, input logic [OP_W-1:0] d);
    op_write = 1'b1; op_waddr = row; op_wdata = d;
    tick();
    op_write = 1'b0;
  endtask

  task automatic op_rd(input logic [RA_W-1:0] row, output logic [OP_W-1:0] d);
    op_read = 1'b1; op_raddr = row;
    tick();
    op_read = 1'b0;
    d = op_rdata;
  endtask

  // One bus transfer; lat counts cycles from request to the completing edge.
  // hold_op > 0 keeps an ALU read asserted for that many cycles.
  task automatic bus_xfer(input logic wr, input logic [RA_W-1:0] row, input logic [WA_W-1:0] word,
                          input logic [31:0] wd, input logic [3:0] be, input int hold_op,
                          output int lat, output logic [31:0] rd);
    int c;
    bus_addr = {row, word}; bus_wdata = wd; bus_be = be;
    bus_write = wr; bus_read = !wr;
    op_read = (hold_op > 0); op_raddr = 6'd5;
    c = 1;
    #1;
    while (bus_waitrequest && c < 100) begin
      tick();
      c++;
      if (c > hold_op) op_read = 1'b0;
      #1;
    end
    check("xfer_done", OP_W'(bus_waitrequest), '0);
    lat = c;
    rd  = bus_rdata;
    tick();
    bus_write = 1'b0; bus_read = 1'b0; op_read = 1'b0;
  endtask

  // Bus write racing an ALU write to the same row; dly 1 hits RMW_RD, 2 hits RMW_WR.
  task automatic rmw_race(input string tag, input logic [RA_W-1:0] row, input logic [31:0] wd, input int dly);
    int c;
    logic [OP_W-1:0] d, e;
    op_wr(row, '1);
    bus_addr = {row, 4'd0}; bus_wdata = wd; bus_be = 4'hF; bus_write = 1'b1;
    for (int i = 0; i < dly; i++) tick();
    op_write = 1'b1; op_waddr = row; op_wdata = '0;
    #1;
    check({tag, "_wait"}, OP_W'(bus_waitrequest), OP_W'(1));
    tick();
    op_write = 1'b0;
    c = dly + 2;
    #1;
    while (bus_waitrequest && c < 100) begin
      tick();
      c++;
    end
    check({tag, "_done"}, OP_W'(bus_waitrequest), '0);
    tick();
    bus_write = 1'b0;
    op_rd(row, d);
    e = '0; e[31:0] = wd;
    check({tag, "_row"}, d, e);
  endtask

  initial begin
    logic [OP_W-1:0] v, d, e, acc;
    logic [31:0]     rd;
    int              lat, cnt, c;
    logic            wlow;

    arstn = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_be = '0; bus_write = 1'b0; bus_read = 1'b0;
    op_read = 1'b0; op_raddr = '0; op_write = 1'b0; op_waddr = '0; op_wdata = '0;
    zeroize = 1'b0;
    tick(); tick();
    check("rst_wait",  OP_W'(bus_waitrequest), OP_W'(1));
    check("rst_rdata", OP_W'(bus_rdata), '0);
    check("rst_oprd",  op_rdata, '0);
    check("rst_busy",  OP_W'(zeroize_busy), '0);
    arstn = 1'b1;
    tick();

    // ALU write/read and write-first forwarding
    v = fill(8'hA5);
    op_wr(6'd5, v);
    op_rd(6'd5, d);
    check("t1_rd", d, v);
    op_write = 1'b1; op_waddr = 6'd5; op_wdata = OP_W'(1);
    op_read  = 1'b1; op_raddr = 6'd5;
    tick();
    op_write = 1'b0; op_read = 1'b0;
    check("t1_fwd", op_rdata, OP_W'(1));
    tick();
    check("t1_hold", op_rdata, OP_W'(1));

    // Byte-enabled RMW
    op_wr(6'd3, '1);
    bus_xfer(1'b1, 6'd3, 4'd0, 32'hDEADBEEF, 4'b0101, 0, lat, rd);
    check("t2_wlat", OP_W'(lat), OP_W'(3));
    op_rd(6'd3, d);
    e = '1; e[31:0] = 32'hFFADFFEF;
    check("t2_row", d, e);
    bus_xfer(1'b0, 6'd3, 4'd0, 32'h0, 4'h0, 0, lat, rd);
    check("t2_rlat", OP_W'(lat), OP_W'(2));
    check("t2_rdata", OP_W'(rd), OP_W'(32'hFFADFFEF));

    // ALU write racing the RMW
    rmw_race("t3_wr", 6'd7, 32'h12345678, 2);
    rmw_race("t3_rd", 6'd8, 32'hCAFEF00D, 1);

    // Partial top word, unmapped words, ALU read priority
    op_wr(6'd10, '1);
    bus_xfer(1'b0, 6'd10, 4'd8, 32'h0, 4'h0, 0, lat, rd);
    check("t4_w8", OP_W'(rd), OP_W'(32'h0000000F));
    bus_xfer(1'b0, 6'd10, 4'd12, 32'h0, 4'h0, 0, lat, rd);
    check("t4_w12", OP_W'(rd), '0);
    bus_xfer(1'b0, 6'd10, 4'd0, 32'h0, 4'h0, 5, lat, rd);
    check("t4_stall_lat", OP_W'(lat), OP_W'(7));
    check("t4_stall_data", OP_W'(rd), OP_W'(32'hFFFFFFFF));
    bus_xfer(1'b1, 6'd10, 4'd12, 32'hDEADBEEF, 4'hF, 0, lat, rd);
    check("t4_w12_wlat", OP_W'(lat), OP_W'(3));
    bus_xfer(1'b1, 6'd10, 4'd8, 32'h0, 4'hF, 0, lat, rd);
    op_rd(6'd10, d);
    e = '1; e[259:256] = 4'h0;
    check("t4_row", d, e);

    // Zeroize sweep
    for (int i = 0; i < N_REG; i++) op_wr(RA_W'(i), OP_W'(i + 1));
    zeroize = 1'b1; bus_addr = {6'd20, 4'd0}; bus_read = 1'b1;
    tick();
    zeroize = 1'b0;
    cnt = 0; wlow = 1'b0;
    while (zeroize_busy && cnt < 200) begin
      cnt++;
      if (!bus_waitrequest) wlow = 1'b1;
      zeroize  = (cnt == 10);
      op_write = (cnt == 40); op_waddr = 6'd5; op_wdata = '1;
      op_read  = (cnt == 30); op_raddr = 6'd50;
      if (cnt == 31) check("t5_oprd_zero", op_rdata, '0);
      tick();
    end
    zeroize = 1'b0; op_write = 1'b0; op_read = 1'b0;
    check("t5_busy_cycles", OP_W'(cnt), OP_W'(N_REG));
    check("t5_no_ack", OP_W'(wlow), '0);
    check("t5_oprd_after", op_rdata, '0);
    c = 0;
    while (bus_waitrequest && c < 10) begin
      tick();
      c++;
    end
    check("t5_bus_done", OP_W'(bus_waitrequest), '0);
    check("t5_bus_rdata", OP_W'(bus_rdata), '0);
    tick();
    bus_read = 1'b0;
    acc = '0;
    for (int i = 0; i < N_REG; i++) begin
      op_rd(RA_W'(i), d);
      acc = acc | d;
    end
    check("t5_all_zero", acc, '0);

    // Reset in the middle of an RMW
    v = fill(8'hA5);
    op_wr(6'd9, v);
    bus_xfer(1'b0, 6'd9, 4'd0, 32'h0, 4'h0, 0, lat, rd);
    check("t6_pre_rdata", OP_W'(rd), OP_W'(32'hA5A5A5A5));
    op_rd(6'd9, d);
    bus_addr = {6'd9, 4'd0}; bus_wdata = 32'h0; bus_be = 4'hF; bus_write = 1'b1;
    tick();
    arstn = 1'b0;
    #1;
    check("t6_rst_wait",  OP_W'(bus_waitrequest), OP_W'(1));
    check("t6_rst_rdata", OP_W'(bus_rdata), '0);
    check("t6_rst_oprd",  op_rdata, '0);
    check("t6_rst_busy",  OP_W'(zeroize_busy), '0);
    bus_write = 1'b0;
    tick();
    arstn = 1'b1;
    tick();
    op_rd(6'd9, d);
    check("t6_row_kept", d, v);
    bus_xfer(1'b1, 6'd9, 4'd0, 32'h11223344, 4'hF, 0, lat, rd);
    check("t6_wlat", OP_W'(lat), OP_W'(3));
    op_rd(6'd9, d);
    e = v; e[31:0] = 32'h11223344;
    check("t6_row_new", d, e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
